// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// audio_pkg : constants shared by the audio input/output paths (9-bit samples)
// Revision  : 1.0
// ============================================================================
package audio_pkg;

  localparam int SAMPLE_W       = 9;
  localparam int DECIM_LOG2     = 9;
  localparam int EAR_HI_TH      = 288;
  localparam int EAR_LO_TH      = 224;
  localparam int AUDIO_MIDSCALE = 256;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/ear_hysteresis.sv
`default_nettype none
// ============================================================================
// ear_hysteresis : two-threshold slicer turning a sample stream into one bit
// Revision       : 1.0
// ============================================================================
module ear_hysteresis
  import audio_pkg::*;
#(
  parameter int W     = SAMPLE_W,
  parameter int HI_TH = EAR_HI_TH,
  parameter int LO_TH = EAR_LO_TH
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] sample,
  input  logic         valid,
  output logic         Ear
);

  localparam logic [W-1:0] c_hi = W'(HI_TH);
  localparam logic [W-1:0] c_lo = W'(LO_TH);

  generate
    if (LO_TH >= HI_TH) begin : g_bad_thresholds
      $error("ear_hysteresis: LO_TH must be below HI_TH");
    end
  endgenerate

  logic r_ear;

  // Between the thresholds the previous decision holds.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ear <= 1'b0;
    end else if (valid) begin
      if (sample >= c_hi) begin
        r_ear <= 1'b1;
      end else if (sample <= c_lo) begin
        r_ear <= 1'b0;
      end
    end
  end

  assign Ear = r_ear;

endmodule : ear_hysteresis
`default_nettype wire

// File: rtl/sigma_delta_adc_ear.sv
`default_nettype none
// ============================================================================
// sigma_delta_adc_ear : first-order sigma-delta ADC for the tape/EAR input,
//                       counting comparator ones over a 2^DECIM_LOG2 window
// Revision            : 1.0
// ============================================================================
module sigma_delta_adc_ear
  import audio_pkg::*;
#(
  parameter int DECIM_LOG2 = audio_pkg::DECIM_LOG2,
  parameter int HI_TH      = EAR_HI_TH,
  parameter int LO_TH      = EAR_LO_TH
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  CompIn,
  output logic                  FbOut,
  output logic [DECIM_LOG2-1:0] Sample,
  output logic                  SampleValid,
  output logic                  Ear
);

  (* ASYNC_REG = "TRUE" *) logic r_s1;
  (* ASYNC_REG = "TRUE" *) logic r_s2;
  (* IOB = "TRUE" *)       logic r_fb;

  logic [DECIM_LOG2-1:0] r_win_cnt;
  logic [DECIM_LOG2:0]   r_ones;
  logic [DECIM_LOG2-1:0] r_sample;
  logic                  r_valid;

  logic                  w_win_end;
  logic [DECIM_LOG2:0]   w_total;
  logic [DECIM_LOG2-1:0] w_sat;

  assign w_win_end = &r_win_cnt;
  assign w_total   = r_ones + {{DECIM_LOG2{1'b0}}, r_s2};
  // Only an all-ones window reaches 2^DECIM_LOG2, so the MSB alone flags overflow.
  assign w_sat     = w_total[DECIM_LOG2] ? {DECIM_LOG2{1'b1}} : w_total[DECIM_LOG2-1:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_fb      <= 1'b0;
      r_win_cnt <= '0;
      r_ones    <= '0;
      r_sample  <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_s1      <= CompIn;
      r_s2      <= r_s1;
      r_fb      <= CompIn;
      r_win_cnt <= r_win_cnt + 1'b1;
      r_valid   <= w_win_end;
      if (w_win_end) begin
        r_sample <= w_sat;
        r_ones   <= '0;
      end else begin
        r_ones   <= w_total;
      end
    end
  end

  ear_hysteresis #(
    .W     (DECIM_LOG2),
    .HI_TH (HI_TH),
    .LO_TH (LO_TH)
  ) u_ear_hysteresis (
    .Clk    (Clk),
    .Reset  (Reset),
    .sample (w_sat),
    .valid  (w_win_end),
    .Ear    (Ear)
  );

  assign FbOut       = r_fb;
  assign Sample      = r_sample;
  assign SampleValid = r_valid;

endmodule : sigma_delta_adc_ear
`default_nettype wire

// File: tb/tb_sigma_delta_adc_ear.sv
`default_nettype none
// ============================================================================
// tb_sigma_delta_adc_ear : directed self-checking bench for sigma_delta_adc_ear
// Revision               : 1.0
// ============================================================================
module tb_sigma_delta_adc_ear;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       CompIn;
  logic       FbOut;
  logic [8:0] Sample;
  logic       SampleValid;
  logic       Ear;

  int ncmp  = 0;
  int nfail = 0;

  sigma_delta_adc_ear #(
    .DECIM_LOG2 (9),
    .HI_TH      (288),
    .LO_TH      (224)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .CompIn      (CompIn),
    .FbOut       (FbOut),
    .Sample      (Sample),
    .SampleValid (SampleValid),
    .Ear         (Ear)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (SampleValid !== 1'b1 && n < 1100);
  endtask

  // Starts on the cycle right after a strobe. n<0 drives a toggle pattern,
  // otherwise n ones then zeros, plus a single one at index g (g<0: none).
  task automatic drive_window(input int n, input int g, input logic ear_prev, input string tag);
    for (int i = 0; i < 512; i++) begin
      CompIn = (n < 0) ? i[0] : ((i < n) || (i == g));
      tick();
      if (i == 510) begin
        check({tag, " valid before end"}, SampleValid, 0);
        check({tag, " ear holds mid-window"}, Ear, ear_prev);
      end
      if (g > 0 && i == g - 1) check({tag, " fb before glitch"}, FbOut, 0);
      if (g >= 0 && i == g)    check({tag, " fb shows glitch"}, FbOut, 1);
      if (g >= 0 && i == g + 1) check({tag, " fb after glitch"}, FbOut, 0);
    end
    check({tag, " valid at window end"}, SampleValid, 1);
  endtask

  int n;
  int bad;
  int duty [5] = '{300, 250, 200, 250, 290};
  logic ear_exp [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic ear_prev;

  initial begin
    Reset  = 1'b1;
    CompIn = 1'b1;
    repeat (3) tick();
    check("reset Sample", Sample, 0);
    check("reset SampleValid", SampleValid, 0);
    check("reset Ear", Ear, 0);
    check("reset FbOut", FbOut, 0);

    // All ones: first window loses the two flushed sync zeros.
    Reset = 1'b0;
    wait_strobe(n);
    check("ones first strobe edge", n, 512);
    check("ones window1 Sample", Sample, 510);
    check("ones window1 Ear", Ear, 1);
    tick();
    check("strobe single cycle", SampleValid, 0);
    check("Sample holds", Sample, 510);
    wait_strobe(n);
    check("ones second strobe spacing", n, 511);
    check("ones window2 saturated", Sample, 511);
    check("ones window2 Ear", Ear, 1);

    // All zeros: two leftover ones from the previous window spill over.
    drive_window(0, -1, 1'b1, "zeros w1");
    check("zeros w1 Sample", Sample, 2);
    check("zeros w1 Ear", Ear, 0);
    drive_window(0, -1, 1'b0, "zeros w2");
    check("zeros w2 Sample", Sample, 0);
    check("zeros w2 Ear", Ear, 0);

    ear_prev = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_window(duty[k], -1, ear_prev, "duty");
      check("duty Sample", Sample, duty[k]);
      check("duty Ear", Ear, ear_exp[k]);
      ear_prev = ear_exp[k];
    end

    // Toggle: first window 255 (tail zeros), then midscale; Ear holds 1.
    drive_window(-1, -1, 1'b1, "toggle w1");
    check("toggle w1 Sample", Sample, 255);
    check("toggle w1 Ear", Ear, 1);
    drive_window(-1, -1, 1'b1, "toggle w2");
    check("toggle w2 Sample", Sample, 256);
    check("toggle w2 Ear", Ear, 1);
    drive_window(-1, -1, 1'b1, "toggle w3");
    check("toggle w3 Sample", Sample, 256);

    drive_window(0, -1, 1'b1, "flush");
    check("flush Sample", Sample, 1);
    check("flush Ear", Ear, 0);
    drive_window(100, -1, 1'b0, "no glitch");
    check("no glitch Sample", Sample, 100);
    drive_window(100, 400, 1'b0, "glitch");
    check("glitch Sample", Sample, 101);
    check("glitch Ear", Ear, 0);

    // Reset pulse mid-window at win_cnt = 300.
    CompIn = 1'b1;
    repeat (300) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midreset Sample", Sample, 0);
    check("midreset Ear", Ear, 0);
    check("midreset SampleValid", SampleValid, 0);
    n = 0;
    bad = 0;
    do begin
      tick();
      n++;
      if (SampleValid !== 1'b1 && (Sample !== 9'd0 || Ear !== 1'b0)) bad = 1;
    end while (SampleValid !== 1'b1 && n < 1100);
    check("midreset strobe edge", n, 512);
    check("midreset outputs held at 0", bad, 0);
    check("midreset Sample", Sample, 510);
    check("midreset Ear", Ear, 1);

    // Reset landing on the window-end edge suppresses the strobe.
    repeat (511) tick();
    Reset = 1'b1;
    tick();
    check("end-edge reset SampleValid", SampleValid, 0);
    check("end-edge reset Sample", Sample, 0);
    Reset = 1'b0;
    wait_strobe(n);
    check("end-edge reset next strobe", n, 512);
    check("end-edge reset Sample after", Sample, 510);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule : tb_sigma_delta_adc_ear
`default_nettype wire

// File: doc/sigma_delta_adc_ear.md
Name: sigma_delta_adc_ear

Overview:
- Audio-input counterpart of the sigma-delta DAC on the audio output path. It digitises the tape/EAR line through an external comparator plus an RC feedback network.
- The block drives the feedback pin and counts comparator ones over a fixed decimation window. The count is the 9-bit sample.
- Each sample goes through a hysteresis slicer that produces the clean `ear` bit for the ULA/ASIC port read.
- Sits at the board I/O edge, in parallel with the mixer, on the same clock.

Parameters:
- DECIM_LOG2, 9: log2 of the decimation window length in Clk cycles. Also sets the sample width.
- HI_TH, 288: sample value at or above which Ear goes to 1.
- LO_TH, 224: sample value at or below which Ear goes to 0. Must satisfy LO_TH < HI_TH; check with an elaboration-time assertion.

Ports:
- Clk  in  1  system clock (same as the mixer).
- Reset  in  1  synchronous, active-high.
- CompIn  in  1  asynchronous comparator output (line level vs. RC-filtered FbOut).
- FbOut  out  1  feedback drive to the RC integrator; place this flip-flop in the IOB.
- Sample  out  DECIM_LOG2  latest decimated sample, unsigned, midscale = 2^(DECIM_LOG2-1).
- SampleValid  out  1  one-cycle strobe; Sample and Ear are updated on the edge that raises it.
- Ear  out  1  hysteresis-sliced tape input bit.

Behaviour:
- Reset is synchronous, active-high, on clock Clk. While Reset is high, every register below is 0: s1, s2, FbOut, win_cnt, ones, Sample, SampleValid, Ear.
- Synchroniser:
  - s1 <= CompIn; s2 <= s1.
  - FbOut <= CompIn, registered in parallel with s1 and identical to it. FbOut therefore follows CompIn one edge late.
  - s2 is the counted bit: two edges of latency from CompIn.
- Window counter:
  - win_cnt is DECIM_LOG2 bits wide, increments every cycle and wraps from 2^DECIM_LOG2-1 to 0.
  - Window end = (win_cnt == all ones).
- Ones accumulator:
  - ones is DECIM_LOG2+1 bits wide.
  - Outside window end: ones <= ones + s2.
  - At window end: total = ones + s2. Then Sample <= min(total, 2^DECIM_LOG2-1), SampleValid <= 1, ones <= 0.
  - The cycle at window end is counted in the closing window, never in the next one.
- Saturation: a window of all ones gives 512 and clamps to 511. No other clamping.
- SampleValid is high for exactly one cycle per window. First assertion is on the 2^DECIM_LOG2-th rising edge after Reset deasserts (edge 512 by default).
- Hysteresis, evaluated on the new total at window end in the same edge:
  - saturated total >= HI_TH -> Ear <= 1.
  - saturated total <= LO_TH -> Ear <= 0.
  - Otherwise Ear holds.
  - Ear changes only on SampleValid edges.
- Sample holds between strobes.
- Reset mid-window: the partial count is discarded and no strobe is produced. Counting restarts from win_cnt = 0 on release.
- Reset asserted on a window-end edge: Reset wins; no SampleValid.
- Sampling is continuous; there is no downstream stall or backpressure.

Decomposition:
- Shared package `audio_pkg`:
  - Default constants: SAMPLE_W = 9, DECIM_LOG2 = 9, EAR_HI_TH = 288, EAR_LO_TH = 224, AUDIO_MIDSCALE = 256.
  - These are shared with the mixer (9-bit sample width).
- One natural sub-module, `ear_hysteresis`:
  - Inputs: Clk, Reset, sample, valid.
  - Output: registered Ear.
  - Thresholds are parameters.
  - It is reusable on the LINE-IN path later.
- The synchroniser, counter and accumulator stay in the top module.

Test Plan:
- CompIn held 1 from reset release -> first SampleValid at edge 512. Sample = 510, because the two reset-flushed sync zeros fall in window 1. Ear = 1. Second window: Sample = 511 (saturated from 512), Ear = 1.
- CompIn held 0 -> Sample = 0 every window, Ear stays 0, SampleValid exactly every 512 cycles.
- CompIn toggling every cycle -> Sample = 256 from the second window on, Ear unchanged from its prior value.
- Drive duty cycles giving sample sequence 300, 250, 200, 250, 290 -> Ear = 1, 1, 0, 0, 1, with each change only on the SampleValid edge.
- Pulse Reset for 1 cycle at win_cnt = 300 with CompIn = 1 -> no strobe at the old window end. Next strobe 512 edges after release. Sample and Ear read 0 until that strobe.
- CompIn single-cycle glitch -> FbOut shows it 1 edge later. It adds exactly 1 to that window's Sample versus a glitch-free run.
